// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: round-robin arbiter sharing one 8N1 UART TX line among
// NCH byte requesters. Drives an external baud generator (baud_ena out,
// baud_tick in) and shifts each granted byte out LSB first.
// Optional even parity: define UART_TX_SCHED_PARITY_EN to insert a parity
// bit after d7 (frame becomes 8E1).
//
//   state | meaning
//   IDLE  | line high, baudgen stopped, waiting for any request
//   FRAME | baudgen running; each tick drives the next frame bit. The tick
//         | with bitcnt == FRAME_LEN closes the frame and either regrants
//         | back-to-back (new start bit on the same tick) or returns to IDLE
module uart_tx_scheduler #(
  parameter int NCH       = 4,
  parameter int STOP_BITS = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NCH-1:0]         req,
  input  logic [8*NCH-1:0]       data,
  output logic [NCH-1:0]         gnt,
  output logic                   baud_ena,
  input  logic                   baud_tick,
  output logic                   tx,
  output logic                   busy,
  output logic [$clog2(NCH)-1:0] cur_ch
);

  localparam int CW = $clog2(NCH);
`ifdef UART_TX_SCHED_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  // frm holds everything after the start bit: data, [parity], stop bits
  localparam int FW        = 8 + PB + STOP_BITS;
  localparam int FRAME_LEN = 1 + FW;
  localparam logic [3:0] END_CNT = 4'(FRAME_LEN);

  typedef enum logic {IDLE, FRAME} state_t;

  state_t          state;
  logic [CW-1:0]   last;
  logic [3:0]      bitcnt;
  logic [FW-1:0]   frm;

  logic            pick_vld;
  logic [CW-1:0]   pick;
  logic [CW-1:0]   cand;
  logic [7:0]      pick_byte;
  logic [NCH-1:0]  pick_oh;
  logic [FW-1:0]   pick_frm;

  // Round-robin scan starting one past the last granted channel
  always_comb begin
    pick_vld = 1'b0;
    pick     = '0;
    cand     = (last == CW'(NCH-1)) ? '0 : last + CW'(1);
    for (int k = 0; k < NCH; k++) begin
      if (!pick_vld && req[cand]) begin
        pick_vld = 1'b1;
        pick     = cand;
      end
      cand = (cand == CW'(NCH-1)) ? '0 : cand + CW'(1);
    end
  end

  // Select the winning byte, build its grant vector and frame payload
  always_comb begin
    pick_byte = '0;
    pick_oh   = '0;
    for (int i = 0; i < NCH; i++) begin
      if (pick == CW'(i)) begin
        pick_byte  = data[8*i +: 8];
        pick_oh[i] = pick_vld;
      end
    end
`ifdef UART_TX_SCHED_PARITY_EN
    pick_frm = {{STOP_BITS{1'b1}}, ^pick_byte, pick_byte};
`else
    pick_frm = {{STOP_BITS{1'b1}}, pick_byte};
`endif
  end

  // Scheduler FSM; all outputs registered, tx only moves on a tick
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      last     <= CW'(NCH-1);
      bitcnt   <= '0;
      frm      <= '1;
      tx       <= 1'b1;
      baud_ena <= 1'b0;
      busy     <= 1'b0;
      gnt      <= '0;
      cur_ch   <= '0;
    end else begin
      gnt <= '0;
      case (state)
        IDLE: begin
          if (pick_vld) begin
            frm      <= pick_frm;
            gnt      <= pick_oh;
            cur_ch   <= pick;
            last     <= pick;
            bitcnt   <= '0;
            baud_ena <= 1'b1;
            busy     <= 1'b1;
            state    <= FRAME;
          end
        end
        FRAME: begin
          if (baud_tick) begin
            if (bitcnt == END_CNT) begin
              if (pick_vld) begin
                // back-to-back: this tick already carries the new start bit
                frm    <= pick_frm;
                gnt    <= pick_oh;
                cur_ch <= pick;
                last   <= pick;
                tx     <= 1'b0;
                bitcnt <= 4'd1;
              end else begin
                tx       <= 1'b1;
                baud_ena <= 1'b0;
                busy     <= 1'b0;
                state    <= IDLE;
              end
            end else if (bitcnt == 4'd0) begin
              tx     <= 1'b0;
              bitcnt <= bitcnt + 4'd1;
            end else begin
              tx     <= frm[0];
              frm    <= {1'b1, frm[FW-1:1]};
              bitcnt <= bitcnt + 4'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
